// File: rtl/cic3_row_readout_pkg.sv
// rtl/cic3_row_readout_pkg.sv - shared constants and types for the CIC3 row readout
package cic3_readout_pkg;

    localparam int NUM_CHANNELS = 24;
    localparam int WORD_W       = 25;
    localparam int CHAN_W       = 5;
    localparam int FRAME_CNT_W  = 8;

    typedef enum logic {IDLE, SEND} readout_state_t;

    typedef logic [WORD_W-1:0] cic_word_t;

endpackage

// File: rtl/cic3_row_readout_if.sv
// rtl/cic3_row_readout_if.sv - filter-row input and word-stream output bundle (CIC3_READOUT_PARITY_EN adds dout_parity)
interface cic3_row_readout_if;
    import cic3_readout_pkg::*;

    logic [NUM_CHANNELS*WORD_W-1:0] filt_in;
    logic                           sample_strobe;
    logic [NUM_CHANNELS-1:0]        chan_enable;
    cic_word_t                      dout;
    logic [CHAN_W-1:0]              dout_chan;
    logic                           dout_valid;
    logic                           dout_ready;
    logic                           dout_last;
    logic                           busy;
    logic                           overflow;
    logic                           overflow_clr;
    logic [FRAME_CNT_W-1:0]         frame_count;
`ifdef CIC3_READOUT_PARITY_EN
    logic                           dout_parity;
`endif

    // master is the readout block, slave is the filter row plus downstream consumer
    modport master (
        input  filt_in, sample_strobe, chan_enable, dout_ready, overflow_clr,
        output dout, dout_chan, dout_valid, dout_last, busy, overflow, frame_count
`ifdef CIC3_READOUT_PARITY_EN
        , output dout_parity
`endif
    );

    modport slave (
        output filt_in, sample_strobe, chan_enable, dout_ready, overflow_clr,
        input  dout, dout_chan, dout_valid, dout_last, busy, overflow, frame_count
`ifdef CIC3_READOUT_PARITY_EN
        , input dout_parity
`endif
    );

endinterface

// File: rtl/cic3_row_readout_next_chan.sv
// rtl/cic3_row_readout_next_chan.sv - combinational finder for the first and next enabled channel
module cic3_readout_next_chan #(
    parameter int N = 24,
    parameter int W = 5
) (
    input  logic [N-1:0] i_mask,
    input  logic [W-1:0] i_ptr,
    output logic [W-1:0] o_first,
    output logic [W-1:0] o_next,
    output logic         o_found,
    output logic         o_last
);

    logic w_above;

    // Scanning downward lets the lowest qualifying index overwrite the others
    always_comb begin
        o_first = '0;
        o_next  = '0;
        w_above = 1'b0;
        for (int i = N-1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_first = W'(i);
                if (W'(i) > i_ptr) begin
                    o_next  = W'(i);
                    w_above = 1'b1;
                end
            end
        end
    end

    assign o_found = |i_mask;
    assign o_last  = ~w_above;

endmodule

// File: rtl/cic3_row_readout.sv
// rtl/cic3_row_readout.sv - snapshots the CIC3 row on each strobe and streams enabled channels (CIC3_READOUT_PARITY_EN)
module cic3_row_readout
    import cic3_readout_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    cic3_row_readout_if.master bus
);

    readout_state_t                 r_state, w_next_state;
    logic [NUM_CHANNELS*WORD_W-1:0] r_snap;
    logic [NUM_CHANNELS-1:0]        r_mask;
    logic [CHAN_W-1:0]              r_ptr;
    logic                           r_overflow;
    logic [FRAME_CNT_W-1:0]         r_frame_count;

    logic [CHAN_W-1:0] w_start_first, w_start_next, w_adv_first, w_adv_next;
    logic              w_start_found, w_start_last, w_adv_found, w_adv_last;
    logic              w_xfer, w_final, w_capture, w_drop, w_advance;
    logic              w_unused;

    cic3_readout_next_chan #(.N(NUM_CHANNELS), .W(CHAN_W)) u_start (
        .i_mask  (bus.chan_enable),
        .i_ptr   ('0),
        .o_first (w_start_first),
        .o_next  (w_start_next),
        .o_found (w_start_found),
        .o_last  (w_start_last)
    );

    cic3_readout_next_chan #(.N(NUM_CHANNELS), .W(CHAN_W)) u_adv (
        .i_mask  (r_mask),
        .i_ptr   (r_ptr),
        .o_first (w_adv_first),
        .o_next  (w_adv_next),
        .o_found (w_adv_found),
        .o_last  (w_adv_last)
    );

    assign w_unused = &{1'b0, w_start_next, w_start_last, w_adv_first, w_adv_found};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A strobe landing on the final transfer starts the next frame with no idle gap
    always_comb begin
        w_next_state = r_state;
        w_xfer       = 1'b0;
        w_final      = 1'b0;
        w_capture    = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.sample_strobe && w_start_found) begin
                    w_capture    = 1'b1;
                    w_next_state = SEND;
                end
            end
            SEND: begin
                w_xfer  = bus.dout_ready;
                w_final = bus.dout_ready & w_adv_last;
                if (w_final) begin
                    if (bus.sample_strobe && w_start_found) begin
                        w_capture = 1'b1;
                    end else begin
                        w_next_state = IDLE;
                    end
                end else if (bus.sample_strobe) begin
                    w_drop = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_advance = w_xfer & ~w_adv_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap        <= '0;
            r_mask        <= '0;
            r_ptr         <= '0;
            r_overflow    <= 1'b0;
            r_frame_count <= '0;
        end else begin
            if (w_capture) begin
                r_snap <= bus.filt_in;
                r_mask <= bus.chan_enable;
                r_ptr  <= w_start_first;
            end else if (w_advance) begin
                r_ptr <= w_adv_next;
            end
            if (w_final) begin
                r_frame_count <= r_frame_count + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.overflow_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.dout        = r_snap[r_ptr*WORD_W +: WORD_W];
    assign bus.dout_chan   = r_ptr;
    assign bus.dout_valid  = (r_state == SEND);
    assign bus.dout_last   = (r_state == SEND) & w_adv_last;
    assign bus.busy        = (r_state == SEND);
    assign bus.overflow    = r_overflow;
    assign bus.frame_count = r_frame_count;
`ifdef CIC3_READOUT_PARITY_EN
    assign bus.dout_parity = ^{r_ptr, bus.dout};
`endif

endmodule
